// File: rtl/alu_seq.sv
// Registered valid/ready ALU (ADD/SUB/AND/OR with Z/N/C/B flags) feeding a 2-entry in-order response FIFO.
// Optional accumulator operand selected by req_use_acc when ALU_SEQ_ACC_EN is defined.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    input  logic [TAGW-1:0]  req_tag,
`ifdef ALU_SEQ_ACC_EN
    input  logic             req_use_acc,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_z,
    output logic             rsp_n,
    output logic             rsp_c,
    output logic             rsp_b,
    output logic [TAGW-1:0]  rsp_tag
);

    localparam int EW = WIDTH + 4 + TAGW;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    logic [EW-1:0]    mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             bo;
    logic             z;
    logic             n;

    // A transfer happens on a rising edge when valid && ready; ready never looks at the far side's valid/ready.
    assign req_ready = (count != 2'd2);
    assign rsp_valid = (count != 2'd0);
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0] acc;
    assign op_a = req_use_acc ? acc : req_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (push) begin
            acc <= y;
        end
    end
`else
    assign op_a = req_a;
`endif

    always_comb begin
        sum  = {1'b0, op_a} + {1'b0, req_b};
        diff = op_a - req_b;
        y    = '0;
        c    = 1'b0;
        bo   = 1'b0;
        case (op_t'(req_op))
            OP_ADD: begin
                y = sum[WIDTH-1:0];
                c = sum[WIDTH];
            end
            OP_SUB: begin
                y  = diff;
                bo = (op_a < req_b);
            end
            OP_AND: y = op_a & req_b;
            OP_OR:  y = op_a | req_b;
            default: y = '0;
        endcase
        z = (y == '0);
        n = y[WIDTH-1];
    end

    // Storage is cleared on reset so the response outputs read zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {req_tag, z, n, c, bo, y};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign {rsp_tag, rsp_z, rsp_n, rsp_c, rsp_b, rsp_y} = mem[rd_ptr];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors, scoreboard queue of expected responses, final report.
// Covers the accumulator sequence when ALU_SEQ_ACC_EN is defined.
module tb_alu_seq;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int EW = W + 4 + TW;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic [1:0]    req_op;
    logic [TW-1:0] req_tag;
    logic          req_use_acc;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_y;
    logic          rsp_z;
    logic          rsp_n;
    logic          rsp_c;
    logic          rsp_b;
    logic [TW-1:0] rsp_tag;

    int checks = 0;
    int errors = 0;

    // expected entry: {tag, z, n, c, b, y}
    logic [EW-1:0] exp_q[$];

    alu_seq #(.WIDTH(W), .TAGW(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_tag    (req_tag),
`ifdef ALU_SEQ_ACC_EN
        .req_use_acc(req_use_acc),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_y      (rsp_y),
        .rsp_z      (rsp_z),
        .rsp_n      (rsp_n),
        .rsp_c      (rsp_c),
        .rsp_b      (rsp_b),
        .rsp_tag    (rsp_tag)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // scoreboard: every negedge with a pending take compares the head against the expected queue
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_tag), 32'hFFFF_FFFF);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("rsp_y", 32'(rsp_y), 32'(e[W-1:0]));
                check("rsp_flags", 32'({rsp_z, rsp_n, rsp_c, rsp_b}), 32'(e[W+3:W]));
                check("rsp_tag", 32'(rsp_tag), 32'(e[EW-1:W+4]));
            end
        end
    end

    // driver: called at posedge+#1, returns at posedge+#1 right after the acceptance edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         input logic [TW-1:0] tag, input logic use_acc,
                         input logic [W-1:0] ey, input logic [3:0] ezncb);
        bit done;
        done        = 1'b0;
        req_valid   = 1'b1;
        req_a       = a;
        req_b       = b;
        req_op      = op;
        req_tag     = tag;
        req_use_acc = use_acc;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back({tag, ezncb, ey});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_a       = '0;
        req_b       = '0;
        req_op      = 2'b00;
        req_tag     = '0;
        req_use_acc = 1'b0;
        rsp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_y", 32'(rsp_y), 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single op latency: visible in the cycle after acceptance
        issue(8'd10, 8'd3, 2'b00, 4'd1, 1'b0, 8'd13, 4'b0000);
        check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
        check("lat_rsp_y", 32'(rsp_y), 32'd13);
        drain();

        // directed arithmetic / boundary vectors
        issue(8'd3,   8'd10,  2'b01, 4'd2, 1'b0, 8'd249, 4'b0101);
        issue(8'd5,   8'd5,   2'b01, 4'd3, 1'b0, 8'd0,   4'b1000);
        issue(8'd200, 8'd100, 2'b00, 4'd4, 1'b0, 8'd44,  4'b0010);
        issue(8'd12,  8'd5,   2'b10, 4'd5, 1'b0, 8'd4,   4'b0000);
        issue(8'd12,  8'd5,   2'b11, 4'd6, 1'b0, 8'd13,  4'b0000);
        issue(8'd128, 8'd128, 2'b00, 4'd7, 1'b0, 8'd0,   4'b1010);
        issue(8'd0,   8'd1,   2'b01, 4'd8, 1'b0, 8'd255, 4'b0101);
        issue(8'h80,  8'h01,  2'b11, 4'd9, 1'b0, 8'h81,  4'b0100);
        drain();

        // backpressure: tags 1,2 fill the FIFO, tag 3 is held until the consumer resumes
        rsp_ready = 1'b0;
        fork
            begin
                issue(8'd1, 8'd2, 2'b00, 4'd1, 1'b0, 8'd3,  4'b0000);
                issue(8'd3, 8'd4, 2'b00, 4'd2, 1'b0, 8'd7,  4'b0000);
                issue(8'd5, 8'd6, 2'b00, 4'd3, 1'b0, 8'd11, 4'b0000);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_req_ready", 32'(req_ready), 32'd0);
                check("bp_head_tag", 32'(rsp_tag), 32'd1);
                check("bp_queued", 32'(exp_q.size()), 32'd2);
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        drain();

        // streaming: six back-to-back ops, one response per cycle, FIFO never fills
        fork
            begin
                issue(8'd1,   8'd1,   2'b00, 4'd4, 1'b0, 8'd2,   4'b0000);
                issue(8'd255, 8'd1,   2'b00, 4'd5, 1'b0, 8'd0,   4'b1010);
                issue(8'd7,   8'd3,   2'b01, 4'd6, 1'b0, 8'd4,   4'b0000);
                issue(8'hF0,  8'h3C,  2'b10, 4'd7, 1'b0, 8'h30,  4'b0000);
                issue(8'h0F,  8'hF0,  2'b11, 4'd8, 1'b0, 8'hFF,  4'b0100);
                issue(8'd100, 8'd200, 2'b01, 4'd9, 1'b0, 8'd156, 4'b0101);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = rsp_valid;
                end
                check("stream_start", 32'(seen), 32'd1);
                for (int i = 0; i < 6; i++) begin
                    check("stream_rsp_valid", 32'(rsp_valid), 32'd1);
                    check("stream_req_ready", 32'(req_ready), 32'd1);
                    if (i < 5) @(negedge clk);
                end
            end
        join
        drain();

        // reset with two responses buffered
        rsp_ready = 1'b0;
        issue(8'd20, 8'd1, 2'b00, 4'd10, 1'b0, 8'd21, 4'b0000);
        issue(8'd30, 8'd1, 2'b00, 4'd11, 1'b0, 8'd31, 4'b0000);
        check("pre_rst_full", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_rsp_y", 32'(rsp_y), 32'd0);
        check("mid_rst_flags", 32'({rsp_z, rsp_n, rsp_c, rsp_b}), 32'd0);
        check("mid_rst_rsp_tag", 32'(rsp_tag), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(8'd9, 8'd9, 2'b00, 4'd12, 1'b0, 8'd18, 4'b0000);
        check("post_rst_first_rsp", 32'(rsp_valid), 32'd1);
        drain();

`ifdef ALU_SEQ_ACC_EN
        // accumulator chain: 5+0, acc+7, acc-2
        issue(8'd5,  8'd0, 2'b00, 4'd1, 1'b0, 8'd5,  4'b0000);
        issue(8'd99, 8'd7, 2'b00, 4'd2, 1'b1, 8'd12, 4'b0000);
        issue(8'd99, 8'd2, 2'b01, 4'd3, 1'b1, 8'd10, 4'b0000);
        drain();
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
